// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer.
package alu_seq_pkg;

    localparam int OP_W   = 4;
    localparam int SEL_W  = 13;
    localparam int DATA_W = 32;
    localparam int Z_W    = 64;
    localparam int CNT_W  = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SHRA = 4'd5;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
    localparam logic [OP_W-1:0] OP_ROR  = 4'd7;
    localparam logic [OP_W-1:0] OP_ROL  = 4'd8;
    localparam logic [OP_W-1:0] OP_AND  = 4'd9;
    localparam logic [OP_W-1:0] OP_OR   = 4'd10;
    localparam logic [OP_W-1:0] OP_NEG  = 4'd11;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decoder: one-hot ALU select, settle time, HI/LO writeback and
// illegal-opcode flag. Purely combinational.
module alu_op_decode
    import alu_seq_pkg::*;
#(
    parameter int BASIC_WAIT = 0,
    parameter int MUL_WAIT   = 2,
    parameter int DIV_WAIT   = 3
) (
    input  logic [OP_W-1:0]  i_op,
    output logic [SEL_W-1:0] o_sel,
    output logic [CNT_W-1:0] o_wait,
    output logic             o_hi_we,
    output logic             o_illegal
);

    // Illegal opcodes select nothing and settle immediately.
    always_comb begin
        o_sel     = '0;
        o_wait    = CNT_W'(BASIC_WAIT);
        o_hi_we   = 1'b0;
        o_illegal = (i_op > OP_NOT);
        if (!o_illegal) begin
            o_sel = SEL_W'(1) << i_op;
        end else begin
            o_wait = '0;
        end
        case (i_op)
            OP_MUL: begin
                o_wait  = CNT_W'(MUL_WAIT);
                o_hi_we = 1'b1;
            end
            OP_DIV: begin
                o_wait  = CNT_W'(DIV_WAIT);
                o_hi_we = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture controller for the combinational ALU. Holds operands and a
// one-hot select for the op's settle time, then captures the 64-bit result
// into Z and presents it on a valid/ready response.
// Optional macro DIVZERO_CHK_EN: short-circuit DIV by zero with a flagged,
// fixed result instead of waiting for the ALU.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BASIC_WAIT = 0,
    parameter int MUL_WAIT   = 2,
    parameter int DIV_WAIT   = 3
) (
    input  logic              i_clock,
    input  logic              i_clear_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [OP_W-1:0]   i_req_op,
    input  logic [DATA_W-1:0] i_req_a,
    input  logic [DATA_W-1:0] i_req_b,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [SEL_W-1:0]  o_alu_sel,
    input  logic [Z_W-1:0]    i_alu_c,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_lo,
    output logic [DATA_W-1:0] o_rsp_hi,
    output logic              o_rsp_hi_we,
    output logic              o_rsp_illegal,
    output logic              o_rsp_divzero
);

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a, r_b;
    logic [SEL_W-1:0]    r_sel;
    logic                r_hi_we, r_illegal, r_divzero;
    logic [Z_W-1:0]      r_z;

    logic [SEL_W-1:0]    w_dec_sel;
    logic [CNT_W-1:0]    w_dec_wait, w_wait;
    logic                w_dec_hi_we, w_dec_illegal, w_dz;
    logic                w_accept, w_capture;

    alu_op_decode #(
        .BASIC_WAIT (BASIC_WAIT),
        .MUL_WAIT   (MUL_WAIT),
        .DIV_WAIT   (DIV_WAIT)
    ) u_decode (
        .i_op      (i_req_op),
        .o_sel     (w_dec_sel),
        .o_wait    (w_dec_wait),
        .o_hi_we   (w_dec_hi_we),
        .o_illegal (w_dec_illegal)
    );

    // Divide-by-zero detection overrides the DIV settle time.
`ifdef DIVZERO_CHK_EN
    assign w_dz   = (i_req_op == OP_DIV) && (i_req_b == '0);
    assign w_wait = w_dz ? '0 : w_dec_wait;
`else
    assign w_dz   = 1'b0;
    assign w_wait = w_dec_wait;
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_clear_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    // Next-state and handshake/select outputs.
    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_alu_sel   = '0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_alu_sel = r_sel;
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand/flag load on accept, settle countdown, Z capture.
    always_ff @(posedge i_clock) begin
        if (!i_clear_n) begin
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sel     <= '0;
            r_hi_we   <= 1'b0;
            r_illegal <= 1'b0;
            r_divzero <= 1'b0;
            r_z       <= '0;
        end else begin
            if (w_accept) begin
                r_a       <= i_req_a;
                r_b       <= i_req_b;
                r_sel     <= w_dec_sel;
                r_hi_we   <= w_dec_hi_we;
                r_illegal <= w_dec_illegal;
                r_divzero <= w_dz;
                r_cnt     <= w_wait;
            end else if (r_state == ST_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                if (r_illegal)      r_z <= '0;
                else if (r_divzero) r_z <= {r_a, 32'hFFFF_FFFF};
                else                r_z <= i_alu_c;
            end
        end
    end

    assign o_alu_a       = r_a;
    assign o_alu_b       = r_b;
    assign o_rsp_lo      = r_z[DATA_W-1:0];
    assign o_rsp_hi      = r_z[Z_W-1:DATA_W];
    assign o_rsp_hi_we   = r_hi_we;
    assign o_rsp_illegal = r_illegal;
    assign o_rsp_divzero = r_divzero;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, transaction-level model with
// per-cycle comparison, and directed ops with literal expectations.
module tb_alu_op_sequencer;

    localparam int BW = 0, MW = 2, DW = 3;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [31:0] alu_a, alu_b;
    logic [12:0] alu_sel;
    logic [63:0] alu_c;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_lo, rsp_hi;
    logic        rsp_hi_we, rsp_illegal, rsp_divzero;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.BASIC_WAIT(BW), .MUL_WAIT(MW), .DIV_WAIT(DW)) dut (
        .i_clock(clk), .i_clear_n(clear_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel), .i_alu_c(alu_c),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_lo(rsp_lo), .o_rsp_hi(rsp_hi), .o_rsp_hi_we(rsp_hi_we),
        .o_rsp_illegal(rsp_illegal), .o_rsp_divzero(rsp_divzero)
    );

    function automatic logic [63:0] alu_fn(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  return {32'b0, a} * {32'b0, b};
            3:  return (b == 0) ? 64'h0 : {a % b, a / b};
            4:  r = a >> b[4:0];
            5:  r = $unsigned($signed(a) >>> b[4:0]);
            6:  r = a << b[4:0];
            7:  r = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
            8:  r = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
            9:  r = a & b;
            10: r = a | b;
            11: r = -a;
            12: r = ~a;
            default: r = '0;
        endcase
        return {32'b0, r};
    endfunction

    // Environment ALU: decode the one-hot select back to an opcode.
    always_comb begin
        int idx;
        idx = -1;
        for (int i = 0; i < 13; i++) if (alu_sel[i]) idx = i;
        alu_c = alu_fn(idx, alu_a, alu_b);
    end

    // Transaction model: 0 idle, 1 busy, 2 responding.
    int          m_phase = 0, m_left = 0;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [63:0] m_z;
    logic        m_hiwe, m_ill, m_dz;

    always @(posedge clk) begin
        if (!clear_n) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    int w;
                    m_op = req_op; m_a = req_a; m_b = req_b;
                    m_ill = (req_op > 12);
                    m_hiwe = (req_op == 2 || req_op == 3);
`ifdef DIVZERO_CHK_EN
                    m_dz = (req_op == 3 && req_b == 0);
`else
                    m_dz = 1'b0;
`endif
                    w = (req_op == 2) ? MW : (req_op == 3 && !m_dz) ? DW : BW;
                    if (m_ill) w = 0;
                    m_z = m_ill ? 64'h0 : m_dz ? {req_a, 32'hFFFF_FFFF} : alu_fn(int'(req_op), req_a, req_b);
                    m_left = w + 1;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (clear_n) begin
            chk("m_req_ready", 64'(req_ready), 64'(m_phase == 0));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
            if (m_phase == 1) begin
                chk("m_alu_sel", 64'(alu_sel), m_ill ? 64'h0 : (64'h1 << m_op));
                chk("m_alu_a", 64'(alu_a), 64'(m_a));
                chk("m_alu_b", 64'(alu_b), 64'(m_b));
            end else begin
                chk("m_alu_sel_idle", 64'(alu_sel), 64'h0);
            end
            if (m_phase == 2) begin
                chk("m_z", {rsp_hi, rsp_lo}, m_z);
                chk("m_hi_we", 64'(rsp_hi_we), 64'(m_hiwe));
                chk("m_illegal", 64'(rsp_illegal), 64'(m_ill));
                chk("m_divzero", 64'(rsp_divzero), 64'(m_dz));
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] elo, input logic [31:0] ehi,
                         input int hold, input bit hs);
        int edges;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        @(negedge clk);
        req_valid = 1'b0;
        edges = 1;
        @(posedge clk); #1;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", 64'(edges), 64'(lat));
        chk("lo", 64'(rsp_lo), 64'(elo));
        chk("hi", 64'(rsp_hi), 64'(ehi));
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_lo", 64'(rsp_lo), 64'(elo));
            chk("hold_ready", 64'(req_ready), 64'h0);
        end
        if (hs) begin
            @(negedge clk); rsp_ready = 1'b1;
            @(posedge clk); #1;
            @(negedge clk); rsp_ready = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_z", {rsp_hi, rsp_lo}, 64'h0);
        chk("rst_alu_sel", 64'(alu_sel), 64'h0);
        @(negedge clk); clear_n = 1'b1;

        do_op(4'd0, 32'd5, 32'd7, 1, 32'd12, 32'd0, 0, 1'b1);
        chk("add_hi_we", 64'(rsp_hi_we), 64'h0);
        do_op(4'd2, 32'h0001_0000, 32'h0001_0000, 3, 32'd0, 32'd1, 0, 1'b0);
        chk("mul_hi_we", 64'(rsp_hi_we), 64'h1);
        @(negedge clk); rsp_ready = 1'b1; @(posedge clk); #1; @(negedge clk); rsp_ready = 1'b0;
        do_op(4'd3, 32'd100, 32'd7, 4, 32'd14, 32'd2, 0, 1'b1);
`ifdef DIVZERO_CHK_EN
        do_op(4'd3, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 32'd9, 0, 1'b0);
        chk("dz_flag", 64'(rsp_divzero), 64'h1);
        chk("dz_hi_we", 64'(rsp_hi_we), 64'h1);
        @(negedge clk); rsp_ready = 1'b1; @(posedge clk); #1; @(negedge clk); rsp_ready = 1'b0;
`endif
        do_op(4'd1, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 32'd0, 0, 1'b1);
        do_op(4'd5, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, 32'd0, 0, 1'b1);
        do_op(4'd8, 32'h8000_0001, 32'd1, 1, 32'h0000_0003, 32'd0, 0, 1'b1);
        do_op(4'd12, 32'd0, 32'd0, 1, 32'hFFFF_FFFF, 32'd0, 0, 1'b1);
        do_op(4'd14, 32'hDEAD_BEEF, 32'h1234_5678, 1, 32'd0, 32'd0, 0, 1'b0);
        chk("ill_flag", 64'(rsp_illegal), 64'h1);
        chk("ill_hi_we", 64'(rsp_hi_we), 64'h0);
        @(negedge clk); rsp_ready = 1'b1; @(posedge clk); #1; @(negedge clk); rsp_ready = 1'b0;

        // SHL held for 5 cycles, then a request queued across the handshake.
        do_op(4'd6, 32'd1, 32'd4, 1, 32'd16, 32'd0, 5, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'd1; req_b = 32'd1;
        @(posedge clk); #1;
        chk("hs_idle_ready", 64'(req_ready), 64'h1);
        chk("hs_idle_valid", 64'(rsp_valid), 64'h0);
        @(negedge clk); rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk("b2b_accepted", 64'(req_ready), 64'h0);
        @(negedge clk); req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_valid", 64'(rsp_valid), 64'h1);
        chk("b2b_lo", 64'(rsp_lo), 64'd2);
        @(negedge clk); rsp_ready = 1'b1; @(posedge clk); #1; @(negedge clk); rsp_ready = 1'b0;

        // Reset in the second EXEC cycle of a DIV discards it.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd3; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); #1;
        @(negedge clk); req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); clear_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h1);
        chk("mid_rst_z", {rsp_hi, rsp_lo}, 64'h0);
        chk("mid_rst_alu_a", 64'(alu_a), 64'h0);
        chk("mid_rst_sel", 64'(alu_sel), 64'h0);
        @(negedge clk); clear_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("no_rsp_after_rst", 64'(rsp_valid), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
